// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: steps the active-low column drive on each tick,
// debounces the first pressed key and reports it as a code pulse plus a held level.
module keypad_scan_ctrl #(
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Detection tick already counts as stable tick 1, so the last count is N-2.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_TICKS - 2);

  function automatic logic [1:0] lowest_low(input logic [3:0] low);
    if (low[0]) begin
      return 2'd0;
    end else if (low[1]) begin
      return 2'd1;
    end else if (low[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  state_e      state_q;
  logic [3:0]  row_meta_q;
  logic [3:0]  row_sync_q;
  logic [1:0]  col_idx_q;
  logic [1:0]  row_idx_q;
  logic [7:0]  cnt_q;
  logic [3:0]  col_n_q;
  logic [3:0]  key_code_q;
  logic        key_valid_q;
  logic        key_held_q;

  logic [3:0]  row_low_d;
  logic        cap_low_d;
  logic [1:0]  col_inc_d;

  assign row_low_d = ~row_sync_q;
  assign cap_low_d = row_low_d[row_idx_q];
  assign col_inc_d = col_idx_q + 2'd1;

  // Row synchronizer, scan/debounce FSM and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      row_meta_q  <= 4'b1111;
      row_sync_q  <= 4'b1111;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      cnt_q       <= 8'd0;
      col_n_q     <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_meta_q  <= row_n;
      row_sync_q  <= row_meta_q;
      key_valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (|row_low_d) begin
              row_idx_q <= lowest_low(row_low_d);
              cnt_q     <= 8'd0;
              state_q   <= DEBOUNCE;
            end else begin
              col_idx_q <= col_inc_d;
              col_n_q   <= col_drive(col_inc_d);
            end
          end
          DEBOUNCE: begin
            if (cap_low_d && (cnt_q == CNT_LAST)) begin
              key_code_q  <= {row_idx_q, col_idx_q};
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
              state_q     <= HELD;
            end else if (cap_low_d) begin
              cnt_q <= cnt_q + 8'd1;
            end else begin
              cnt_q     <= 8'd0;
              col_idx_q <= col_inc_d;
              col_n_q   <= col_drive(col_inc_d);
              state_q   <= SCAN;
            end
          end
          HELD: begin
            if (!cap_low_d) begin
              cnt_q   <= 8'd0;
              state_q <= RELEASE;
            end else begin
              state_q <= HELD;
            end
          end
          RELEASE: begin
            if (!cap_low_d && (cnt_q == CNT_LAST)) begin
              key_held_q <= 1'b0;
              col_idx_q  <= col_inc_d;
              col_n_q    <= col_drive(col_inc_d);
              state_q    <= SCAN;
            end else if (!cap_low_d) begin
              cnt_q <= cnt_q + 8'd1;
            end else begin
              cnt_q   <= 8'd0;
              state_q <= HELD;
            end
          end
          default: begin
            state_q <= SCAN;
          end
        endcase
      end
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the calculator's 4x4 matrix keypad. It uses the one-cycle 1 kHz `tick` enable from the clock-divider path to step the column drive. It then debounces the first pressed key and emits one `key_valid` pulse with a 4-bit key code per debounced press, plus a level `key_held` until debounced release. It sits between the keypad pins and the calculator's input/operand logic.

## Interface
- `DEBOUNCE_TICKS`, default 20: consecutive stable ticks required for press and for release; legal range 2..255.
- `clk`  in  1: system clock; all logic on posedge.
- `rst`  in  1: asynchronous, active-high reset.
- `tick`  in  1: one-`clk`-wide enable at about 1 kHz; all scan and debounce activity advances only on cycles where `tick` = 1.
- `row_n`  in  4: keypad rows, active-low, asynchronous to `clk`.
- `col_n`  out  4: column drive, active-low; exactly one bit is 0 at all times.
- `key_code`  out  4: last debounced key, `{row_idx[1:0], col_idx[1:0]}`.
- `key_valid`  out  1: one-`clk` pulse per debounced press.
- `key_held`  out  1: high from the debounced press until the debounced release.

## Operation
- `row_n` passes through a 2-flop synchronizer (reset value 4'b1111). "Row low" below always refers to the synchronized value.
- Internal state:
  - `col_idx` (2 bits)
  - captured `row_idx` (2 bits)
  - 8-bit tick counter `cnt`
  - FSM with states SCAN, DEBOUNCE, HELD, RELEASE
- `col_n` = ~(1 << `col_idx`).
- **SCAN**, on tick:
  - If any row is low: capture the lowest-index low row, clear `cnt`, go to DEBOUNCE. `col_idx` stays put.
  - Otherwise: `col_idx` increments by 1 modulo 4 (3 wraps to 0).
- **DEBOUNCE**, on tick (column frozen):
  - If the captured row is still low and `cnt` = DEBOUNCE_TICKS-2: load `key_code`, pulse `key_valid`, set `key_held`, go to HELD. The first detection counts as stable tick 1, so a key stable for DEBOUNCE_TICKS ticks is accepted.
  - If the captured row is still low otherwise: `cnt`++.
  - If the captured row is high: clear `cnt`, advance `col_idx`, return to SCAN. No output change.
- **HELD**, on tick: if the captured row is high, clear `cnt` and go to RELEASE. Other rows are ignored.
- **RELEASE**, on tick:
  - If the captured row is high and `cnt` = DEBOUNCE_TICKS-2: clear `key_held`, advance `col_idx`, go to SCAN.
  - If the captured row is high otherwise: `cnt`++.
  - If the captured row is low: go back to HELD with `cnt` cleared. No new `key_valid`.
- Only the captured key is tracked. Presses on other keys while in HELD or RELEASE are ignored, with no rollover.
- `key_code` holds its value until the next accepted press.
- A `tick` held high for several consecutive cycles is treated as one step per cycle; no extra protection.

## Timing
- Reset values:
  - `col_n` = 4'b1110
  - `key_code` = 4'h0
  - `key_valid` = 0
  - `key_held` = 0
  - state SCAN, `cnt` = 0, `col_idx` = 0
- `rst` takes effect immediately (asynchronous), including mid-DEBOUNCE or mid-HELD. No pulse is emitted on reset exit.
- All outputs are registered.
  - `col_n` updates on the `clk` edge where `tick` = 1.
  - Rows are evaluated on the next tick, which gives one tick period of column settle time.
- `key_valid`, `key_code` and `key_held` update on the same `clk` edge as the accepting tick. `key_valid` deasserts on the following edge.
- Input latency: a row change reaches the FSM 2 `clk` cycles after it appears on the pin (synchronizer).
- Press-to-`key_valid`, with a key stable from before a tick: DEBOUNCE_TICKS ticks after first detection, counting the detection tick as tick 1.
- Between ticks, state and outputs hold, except that `key_valid` returns to 0.

## Test plan
All scenarios use DEBOUNCE_TICKS = 4 and `tick` pulsed every 10 `clk` cycles.

- **Reset and idle scan:** assert `rst`, then release with `row_n` = 4'b1111. Required: all outputs at reset values. `col_n` then steps 1110 → 1101 → 1011 → 0111 → 1110, one step per tick, and `key_valid` never asserts.
- **Clean press:** hold row 2 low while column 1 is driven. Required: `col_n` freezes at 1101; exactly one `key_valid` pulse, 4 ticks after detection, with `key_code` = 4'h9 and `key_held` = 1.
- **Bounce rejection:** row 2 low for 2 ticks, then high. Required: no `key_valid`, `key_held` stays 0, and scanning resumes at the next column.
- **Release and re-press glitch:**
  - From HELD, row high for 2 ticks, then low for 1 tick. Required: back to HELD, `key_held` stays 1, no new pulse.
  - Then row high for 4 ticks. Required: `key_held` = 0 and scanning resumes.
- **Multiple rows:** rows 1 and 3 low together on column 2. Required: `key_code` = 4'h6 (lowest row index wins).
- **Reset mid-operation:** assert `rst` during DEBOUNCE and again during HELD. Required: outputs go to reset values in the same cycle and no `key_valid` appears after release of reset.
